laser_fire_scheduler: RTL and testbench

//  Schedules laser shots for both shooters (0 = cowboy, 1 = alien) onto a shared pool of NUM_SLOTS laser sprites.
//  Per shooter it latches fire requests, enforces a frame-based cooldown and arbitrates contested frames round-robin.
//  It picks a free slot and issues a one-cycle spawn command to the laser motion blocks.

---
 rtl/laser_pkg.sv | 13 +
 rtl/laser_fire_scheduler_free_slot_finder.sv | 25 ++
 rtl/laser_fire_scheduler.sv | 156 +++++++++++++++
 tb/tb_laser_fire_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared state encoding and shooter identifiers for the laser fire scheduler.
package laser_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_RUN,
    SCH_GAMEOVER
  } sch_state_t;

  localparam int SHOOTER_COWBOY = 0;
  localparam int SHOOTER_ALIEN  = 1;

endpackage

// File: rtl/laser_fire_scheduler_free_slot_finder.sv
// Combinational priority encoder: reports the lowest-index slot whose busy bit is clear.
module free_slot_finder
  import laser_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic [NUM_SLOTS-1:0] busy,
  output logic                 found,
  output logic [SLOT_W-1:0]    index
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        index = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/laser_fire_scheduler.sv
// Laser fire scheduler: latches per-shooter fire requests, applies frame cooldowns,
// arbitrates contested frames round-robin and spawns lasers into free sprite slots.
module laser_fire_scheduler
  import laser_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic                 start,
  input  logic                 GG,
  input  logic [1:0]           fire_req,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic                 spawn_valid,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic                 spawn_owner,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [1:0]           cooldown_active,
  output logic                 clear_all
);

  localparam int              CD_W    = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  sch_state_t state_q, state_d;
  logic                      frame_q, frame_d;
  logic [1:0]                fire_q, fire_d;
  logic [1:0]                pending_q, pending_d;
  logic [1:0][CD_W-1:0]      cd_q, cd_d;
  logic                      rr_q, rr_d;
  logic [NUM_SLOTS-1:0]      busy_q, busy_d;
  logic                      spawn_valid_q, spawn_valid_d;
  logic [SLOT_W-1:0]         spawn_slot_q, spawn_slot_d;
  logic                      spawn_owner_q, spawn_owner_d;
  logic                      clear_all_q, clear_all_d;

  logic                      tick;
  logic [1:0]                fire_rise;
  logic [1:0]                eligible;
  logic                      slot_found;
  logic [SLOT_W-1:0]         free_idx;
  logic                      grant;
  logic                      grant_owner;

  free_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_free_slot_finder (
    .busy  (busy_q),
    .found (slot_found),
    .index (free_idx)
  );

  // Grants look only at registered busy/pending/cooldown, so a same-cycle
  // slot_done, key press or decrement cannot influence this tick's choice.
  always_comb begin
    tick      = frame_clk & ~frame_q;
    fire_rise = fire_req & ~fire_q;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = pending_q[i] & (cd_q[i] == '0);
    end
    grant       = tick & (|eligible) & slot_found;
    grant_owner = (eligible == 2'b11) ? rr_q : eligible[1];

    state_d       = state_q;
    frame_d       = frame_clk;
    fire_d        = fire_req;
    pending_d     = pending_q;
    cd_d          = cd_q;
    rr_d          = rr_q;
    busy_d        = busy_q;
    spawn_valid_d = 1'b0;
    spawn_slot_d  = '0;
    spawn_owner_d = 1'b0;
    clear_all_d   = 1'b0;

    case (state_q)
      SCH_IDLE: begin
        if (start) state_d = SCH_RUN;
      end
      SCH_RUN: begin
        if (GG) begin
          state_d     = SCH_GAMEOVER;
          clear_all_d = 1'b1;
          busy_d      = '0;
          pending_d   = '0;
          cd_d        = '0;
        end else begin
          busy_d = busy_q & ~slot_done;
          if (tick) begin
            for (int i = 0; i < 2; i++) begin
              if (cd_q[i] != '0) cd_d[i] = cd_q[i] - CD_W'(1);
            end
          end
          if (grant) begin
            spawn_valid_d          = 1'b1;
            spawn_slot_d           = free_idx;
            spawn_owner_d          = grant_owner;
            busy_d[free_idx]       = 1'b1;
            pending_d[grant_owner] = 1'b0;
            cd_d[grant_owner]      = CD_LOAD;
            if (eligible == 2'b11) rr_d = ~rr_q;
          end
          // A fresh press landing on the grant cycle stays latched for later.
          pending_d = pending_d | fire_rise;
        end
      end
      SCH_GAMEOVER: begin
        state_d = SCH_GAMEOVER;
      end
      default: begin
        state_d = SCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= SCH_IDLE;
      frame_q       <= 1'b0;
      fire_q        <= '0;
      pending_q     <= '0;
      cd_q          <= '0;
      rr_q          <= 1'b0;
      busy_q        <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_owner_q <= 1'b0;
      clear_all_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      fire_q        <= fire_d;
      pending_q     <= pending_d;
      cd_q          <= cd_d;
      rr_q          <= rr_d;
      busy_q        <= busy_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_owner_q <= spawn_owner_d;
      clear_all_q   <= clear_all_d;
    end
  end

  assign spawn_valid                     = spawn_valid_q;
  assign spawn_slot                      = spawn_slot_q;
  assign spawn_owner                     = spawn_owner_q;
  assign slot_busy                       = busy_q;
  assign clear_all                       = clear_all_q;
  assign cooldown_active[SHOOTER_COWBOY] = (cd_q[SHOOTER_COWBOY] != '0);
  assign cooldown_active[SHOOTER_ALIEN]  = (cd_q[SHOOTER_ALIEN] != '0);

endmodule

// File: tb/tb_laser_fire_scheduler.sv
// Scoreboard bench for laser_fire_scheduler: a per-cycle reference model predicts
// spawns and clears into queues, and an independent monitor pops and compares them.
module tb_laser_fire_scheduler;

  localparam int NUM_SLOTS       = 4;
  localparam int COOLDOWN_FRAMES = 20;
  localparam int SLOT_W          = 2;
  localparam int FRAME_P         = 4;

  logic                 Clk = 1'b0;
  logic                 Reset_n;
  logic                 frame_clk;
  logic                 start;
  logic                 GG;
  logic [1:0]           fire_req;
  logic [NUM_SLOTS-1:0] slot_done;
  logic                 spawn_valid;
  logic [SLOT_W-1:0]    spawn_slot;
  logic                 spawn_owner;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [1:0]           cooldown_active;
  logic                 clear_all;

  always #5 Clk = ~Clk;

  laser_fire_scheduler #(
    .NUM_SLOTS       (NUM_SLOTS),
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
    .SLOT_W          (SLOT_W)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .frame_clk       (frame_clk),
    .start           (start),
    .GG              (GG),
    .fire_req        (fire_req),
    .slot_done       (slot_done),
    .spawn_valid     (spawn_valid),
    .spawn_slot      (spawn_slot),
    .spawn_owner     (spawn_owner),
    .slot_busy       (slot_busy),
    .cooldown_active (cooldown_active),
    .clear_all       (clear_all)
  );

  typedef struct {
    int edge_n;
    int slot;
    int owner;
  } spawn_t;

  spawn_t spawn_q[$];
  int     clear_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  int                   m_mode = 0;
  bit [1:0]             m_pend = '0;
  int                   m_cd[2] = '{0, 0};
  bit [NUM_SLOTS-1:0]   m_busy = '0;
  int                   m_rr = 0;
  bit                   m_prev_frame = 1'b0;
  bit [1:0]             m_prev_fire = '0;
  logic [NUM_SLOTS-1:0] exp_busy = '0;
  logic [1:0]           exp_cd = '0;
  int                   drv_edge = 0;
  int                   mon_edge = 0;
  int                   frame_phase = 0;
  spawn_t               mon_e;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, mon_edge);
    end
  endtask

  // Reference model: what the scheduler should do at the coming clock edge.
  task automatic modelStep();
    bit       tick;
    bit [1:0] rise;
    bit [1:0] elig;
    int       free;
    int       winner;
    spawn_t   s;
    if (!Reset_n) begin
      m_mode       = 0;
      m_pend       = '0;
      m_cd[0]      = 0;
      m_cd[1]      = 0;
      m_busy       = '0;
      m_rr         = 0;
      m_prev_frame = 1'b0;
      m_prev_fire  = '0;
    end else begin
      tick         = frame_clk && !m_prev_frame;
      rise         = fire_req & ~m_prev_fire;
      m_prev_frame = frame_clk;
      m_prev_fire  = fire_req;
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (GG) begin
          m_mode  = 2;
          m_pend  = '0;
          m_cd[0] = 0;
          m_cd[1] = 0;
          m_busy  = '0;
          clear_q.push_back(drv_edge);
        end else begin
          winner = -1;
          free   = -1;
          if (tick) begin
            for (int k = NUM_SLOTS - 1; k >= 0; k--) if (!m_busy[k]) free = k;
            for (int i = 0; i < 2; i++) elig[i] = m_pend[i] && (m_cd[i] == 0);
            if (free >= 0) begin
              if (elig == 2'b11) begin
                winner = m_rr;
                m_rr   = 1 - m_rr;
              end else if (elig[0]) winner = 0;
              else if (elig[1]) winner = 1;
            end
            for (int i = 0; i < 2; i++) if (m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
          end
          for (int k = 0; k < NUM_SLOTS; k++) if (slot_done[k]) m_busy[k] = 1'b0;
          if (winner >= 0) begin
            m_busy[free]   = 1'b1;
            m_pend[winner] = 1'b0;
            m_cd[winner]   = COOLDOWN_FRAMES;
            s.edge_n = drv_edge;
            s.slot   = free;
            s.owner  = winner;
            spawn_q.push_back(s);
          end
          for (int i = 0; i < 2; i++) if (rise[i]) m_pend[i] = 1'b1;
        end
      end
    end
    exp_busy = m_busy;
    exp_cd   = {m_cd[1] != 0, m_cd[0] != 0};
    drv_edge++;
  endtask

  // One clock cycle of stimulus; frame_clk runs FRAME_P cycles per frame.
  task automatic applyStimulus();
    frame_clk = ((frame_phase % FRAME_P) < (FRAME_P / 2));
    frame_phase++;
    modelStep();
    @(negedge Clk);
    start     = 1'b0;
    slot_done = '0;
  endtask

  task automatic waitTicks(input int n);
    repeat (n * FRAME_P) applyStimulus();
  endtask

  task automatic alignTick();
    while ((frame_phase % FRAME_P) != 0) applyStimulus();
  endtask

  always @(posedge Clk) begin
    #1;
    if (spawn_valid === 1'b1) begin
      if (spawn_q.size() > 0 && spawn_q[0].edge_n == mon_edge) begin
        mon_e = spawn_q.pop_front();
        checkOutput("spawn_slot", 32'(spawn_slot), mon_e.slot);
        checkOutput("spawn_owner", 32'(spawn_owner), mon_e.owner);
      end else begin
        checkOutput("spawn_unexpected", 1, 0);
      end
    end else if (spawn_q.size() > 0 && spawn_q[0].edge_n <= mon_edge) begin
      checkOutput("spawn_valid", 32'(spawn_valid), 1);
      void'(spawn_q.pop_front());
    end else begin
      checkOutput("spawn_valid_idle", 32'(spawn_valid), 0);
    end
    if (clear_all === 1'b1) begin
      if (clear_q.size() > 0 && clear_q[0] == mon_edge) void'(clear_q.pop_front());
      else checkOutput("clear_all_unexpected", 1, 0);
    end else if (clear_q.size() > 0 && clear_q[0] <= mon_edge) begin
      checkOutput("clear_all", 32'(clear_all), 1);
      void'(clear_q.pop_front());
    end
    checkOutput("slot_busy", 32'(slot_busy), 32'(exp_busy));
    checkOutput("cooldown_active", 32'(cooldown_active), 32'(exp_cd));
    mon_edge++;
  end

  initial begin
    Reset_n   = 1'b0;
    start     = 1'b0;
    GG        = 1'b0;
    fire_req  = '0;
    slot_done = '0;
    frame_clk = 1'b0;
    repeat (3) applyStimulus();
    Reset_n = 1'b1;
    repeat (2) applyStimulus();

    $display("[TB] fire in IDLE must be ignored");
    fire_req = 2'b01;
    waitTicks(2);
    fire_req = 2'b00;
    applyStimulus();
    start = 1'b1;
    applyStimulus();

    $display("[TB] first cowboy shot, then refire during cooldown");
    fire_req = 2'b01;
    waitTicks(2);
    fire_req = 2'b00;
    applyStimulus();
    fire_req = 2'b01;
    waitTicks(24);
    fire_req = 2'b00;

    $display("[TB] contested frames and round-robin");
    slot_done = 4'b0011;
    applyStimulus();
    waitTicks(22);
    fire_req = 2'b11;
    waitTicks(3);
    fire_req = 2'b00;
    waitTicks(22);
    fire_req = 2'b11;
    waitTicks(3);
    fire_req = 2'b00;

    $display("[TB] all slots busy, then release slot 2");
    waitTicks(22);
    fire_req = 2'b10;
    waitTicks(3);
    slot_done = 4'b0100;
    applyStimulus();
    waitTicks(2);
    fire_req = 2'b00;

    $display("[TB] slot_done on the grant tick");
    slot_done = 4'b1000;
    applyStimulus();
    alignTick();
    applyStimulus();
    fire_req = 2'b01;
    applyStimulus();
    alignTick();
    slot_done = 4'b0001;
    applyStimulus();
    fire_req = 2'b00;
    waitTicks(2);

    $display("[TB] game over with live lasers and a pending request");
    slot_done = 4'b1100;
    applyStimulus();
    waitTicks(22);
    fire_req = 2'b10;
    applyStimulus();
    GG = 1'b1;
    applyStimulus();
    fire_req = 2'b11;
    waitTicks(3);
    fire_req = 2'b00;
    GG       = 1'b0;
    Reset_n  = 1'b0;
    repeat (2) applyStimulus();
    Reset_n = 1'b1;
    applyStimulus();

    $display("[TB] randomized play");
    start = 1'b1;
    applyStimulus();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) fire_req[0] = ~fire_req[0];
      if ($urandom_range(7) == 0) fire_req[1] = ~fire_req[1];
      for (int k = 0; k < NUM_SLOTS; k++) slot_done[k] = ($urandom_range(5) == 0);
      GG      = ($urandom_range(999) == 0);
      Reset_n = !((m_mode == 2 && $urandom_range(9) == 0) || $urandom_range(1999) == 0);
      if (m_mode == 0) start = ($urandom_range(3) == 0);
      applyStimulus();
    end

    GG       = 1'b0;
    Reset_n  = 1'b1;
    fire_req = 2'b00;
    repeat (3) applyStimulus();
    checkOutput("spawn_queue_drained", spawn_q.size(), 0);
    checkOutput("clear_queue_drained", clear_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
